bp_be_pipe_sys_gen: RTL and testbench

- Parametrised system-pipe front end for the BE calculator.
- Carries dispatched CSR commands, PC and instruction through a configurable-depth commit pipeline.
- Gates CSR side effects on commit.
- Arbitrates N prioritised interrupt sources, draining in-flight work before signalling an interrupt take to the CSR unit.

---
 rtl/bp_be_pkg.sv | 37 +++
 rtl/bp_be_pipe_sys_gen_if.sv | 66 ++++++
 rtl/bp_be_sys_irq_arb.sv | 86 ++++++++
 rtl/bp_be_pipe_sys_gen.sv | 117 +++++++++++
 tb/tb_bp_be_pipe_sys_gen.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_pkg.sv
// ============================================================================
// Module : bp_be_pkg
// Brief  : Shared types for the BE system pipe: stage record and interrupt FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bp_be_pkg;

    // Stage fields are sized for the widest supported configuration.
    localparam int bp_be_vaddr_max_lp = 64;
    localparam int bp_be_instr_max_lp = 64;
    localparam int bp_be_data_max_lp  = 64;

    typedef enum logic [1:0] {
        e_sys_idle  = 2'd0,
        e_sys_drain = 2'd1,
        e_sys_take  = 2'd2
    } bp_be_sys_irq_state_e;

    typedef struct packed {
        logic                          v;
        logic                          csr_v;
        logic [3:0]                    op;
        logic [11:0]                   addr;
        logic [bp_be_data_max_lp-1:0]  data;
        logic [bp_be_vaddr_max_lp-1:0] pc;
        logic [bp_be_instr_max_lp-1:0] instr;
    } bp_be_sys_stage_s;

    function automatic int bsg_safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_be_pipe_sys_gen_if.sv
// ============================================================================
// Module : bp_be_pipe_sys_gen_if
// Brief  : Dispatch, commit and interrupt bundle of the BE system pipe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface bp_be_pipe_sys_gen_if
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p    = 39,
    parameter int instr_width_p    = 32,
    parameter int csr_data_width_p = 64,
    parameter int num_irq_p        = 3
);
    localparam int irq_id_width_lp = bsg_safe_clog2(num_irq_p);

    logic                        v_i;
    logic                        poison_i;
    logic                        flush_i;
    logic                        csr_v_i;
    logic [3:0]                  csr_op_i;
    logic [11:0]                 csr_addr_i;
    logic [csr_data_width_p-1:0] csr_data_i;
    logic [vaddr_width_p-1:0]    pc_i;
    logic [instr_width_p-1:0]    instr_i;
    logic                        ready_o;
    logic                        commit_v_i;
    logic                        exc_v_i;
    logic                        mem_ready_i;
    logic                        long_ready_i;
    logic                        commit_v_o;
    logic                        commit_csr_v_o;
    logic [3:0]                  commit_csr_op_o;
    logic [11:0]                 commit_csr_addr_o;
    logic [csr_data_width_p-1:0] commit_csr_data_o;
    logic [vaddr_width_p-1:0]    commit_pc_o;
    logic [instr_width_p-1:0]    commit_instr_o;
    logic [num_irq_p-1:0]        irq_pending_i;
    logic [num_irq_p-1:0]        irq_enable_i;
    logic                        irq_v_o;
    logic [irq_id_width_lp-1:0]  irq_id_o;
    logic [31:0]                 stat_irq_cnt_o;
    logic [31:0]                 stat_drain_cnt_o;

    modport master (
        output v_i, poison_i, flush_i, csr_v_i, csr_op_i, csr_addr_i, csr_data_i,
               pc_i, instr_i, commit_v_i, exc_v_i, mem_ready_i, long_ready_i,
               irq_pending_i, irq_enable_i,
        input  ready_o, commit_v_o, commit_csr_v_o, commit_csr_op_o, commit_csr_addr_o,
               commit_csr_data_o, commit_pc_o, commit_instr_o, irq_v_o, irq_id_o,
               stat_irq_cnt_o, stat_drain_cnt_o
    );

    modport slave (
        input  v_i, poison_i, flush_i, csr_v_i, csr_op_i, csr_addr_i, csr_data_i,
               pc_i, instr_i, commit_v_i, exc_v_i, mem_ready_i, long_ready_i,
               irq_pending_i, irq_enable_i,
        output ready_o, commit_v_o, commit_csr_v_o, commit_csr_op_o, commit_csr_addr_o,
               commit_csr_data_o, commit_pc_o, commit_instr_o, irq_v_o, irq_id_o,
               stat_irq_cnt_o, stat_drain_cnt_o
    );

endinterface

`default_nettype wire

// File: rtl/bp_be_sys_irq_arb.sv
// ============================================================================
// Module : bp_be_sys_irq_arb
// Brief  : Fixed-priority interrupt select, ID latch and drain/take FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bp_be_sys_irq_arb
    import bp_be_pkg::*;
#(
    parameter int num_irq_p       = 3,
    parameter int irq_id_width_lp = bsg_safe_clog2(num_irq_p)
) (
    input  wire logic                       clk_i,
    input  wire logic                       reset_i,
    input  wire logic [num_irq_p-1:0]       irq_pending_i,
    input  wire logic [num_irq_p-1:0]       irq_enable_i,
    input  wire logic                       pipe_empty_i,
    input  wire logic                       mem_ready_i,
    input  wire logic                       long_ready_i,
    input  wire logic                       commit_v_i,
    output logic                            ready_o,
    output logic                            irq_v_o,
    output logic [irq_id_width_lp-1:0]      irq_id_o,
    output bp_be_sys_irq_state_e            state_o
);

    bp_be_sys_irq_state_e       state_q, state_d;
    logic [irq_id_width_lp-1:0] id_q, id_d;
    logic [num_irq_p-1:0]       w_masked;
    logic [irq_id_width_lp-1:0] w_win_id;
    logic                       w_any;

    assign w_masked = irq_pending_i & irq_enable_i;
    assign w_any    = |w_masked;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        w_win_id = '0;
        for (int i = num_irq_p - 1; i >= 0; i--) begin
            if (w_masked[i]) w_win_id = irq_id_width_lp'(i);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_sys_idle;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            e_sys_idle: begin
                if (w_any) begin
                    id_d    = w_win_id;
                    state_d = e_sys_drain;
                end
            end
            e_sys_drain: begin
                if (!w_masked[id_q])
                    state_d = e_sys_idle;
                else if (pipe_empty_i && mem_ready_i && long_ready_i && !commit_v_i)
                    state_d = e_sys_take;
            end
            e_sys_take:  state_d = e_sys_idle;
            default:     state_d = e_sys_idle;
        endcase
    end

    always_comb begin
        ready_o = (state_q == e_sys_idle);
        irq_v_o = (state_q == e_sys_take);
    end

    assign irq_id_o = id_q;
    assign state_o  = state_q;

endmodule

`default_nettype wire

// File: rtl/bp_be_pipe_sys_gen.sv
// ============================================================================
// Module : bp_be_pipe_sys_gen
// Brief  : System-pipe commit pipeline with commit-gated CSR fire and
//          interrupt drain. Statistics counters: BP_BE_PIPE_SYS_GEN_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bp_be_pipe_sys_gen
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p    = 39,
    parameter int instr_width_p    = 32,
    parameter int csr_data_width_p = 64,
    parameter int stages_p         = 2,
    parameter int num_irq_p        = 3
) (
    input  wire logic             clk_i,
    input  wire logic             reset_i,
    bp_be_pipe_sys_gen_if.slave   sys_if
);

    localparam int irq_id_width_lp = bsg_safe_clog2(num_irq_p);

    bp_be_sys_stage_s     stage_q [stages_p];
    bp_be_sys_stage_s     stage0_d;
    bp_be_sys_stage_s     w_last;
    logic                 w_pipe_empty;
    bp_be_sys_irq_state_e w_irq_state;

    // Payload is captured on any dispatch; only the valid bit honours squash.
    always_comb begin
        stage0_d   = stage_q[0];
        stage0_d.v = sys_if.v_i & ~sys_if.poison_i & ~sys_if.flush_i;
        if (sys_if.v_i) begin
            stage0_d.csr_v = sys_if.csr_v_i;
            stage0_d.op    = sys_if.csr_op_i;
            stage0_d.addr  = sys_if.csr_addr_i;
            stage0_d.data  = bp_be_data_max_lp'(sys_if.csr_data_i);
            stage0_d.pc    = bp_be_vaddr_max_lp'(sys_if.pc_i);
            stage0_d.instr = bp_be_instr_max_lp'(sys_if.instr_i);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < stages_p; k++) stage_q[k] <= '0;
        end else begin
            stage_q[0] <= stage0_d;
            for (int k = 1; k < stages_p; k++) begin
                stage_q[k] <= stage_q[k-1];
                if (sys_if.flush_i) stage_q[k].v <= 1'b0;
            end
        end
    end

    always_comb begin
        w_pipe_empty = 1'b1;
        for (int k = 0; k < stages_p; k++) begin
            if (stage_q[k].v) w_pipe_empty = 1'b0;
        end
    end

    assign w_last = stage_q[stages_p-1];

    assign sys_if.commit_v_o        = w_last.v;
    assign sys_if.commit_csr_v_o    = w_last.v & w_last.csr_v & sys_if.commit_v_i & ~sys_if.exc_v_i;
    assign sys_if.commit_csr_op_o   = w_last.op;
    assign sys_if.commit_csr_addr_o = w_last.addr;
    assign sys_if.commit_csr_data_o = csr_data_width_p'(w_last.data);
    assign sys_if.commit_pc_o       = vaddr_width_p'(w_last.pc);
    assign sys_if.commit_instr_o    = instr_width_p'(w_last.instr);

    bp_be_sys_irq_arb #(
        .num_irq_p       (num_irq_p),
        .irq_id_width_lp (irq_id_width_lp)
    ) u_irq_arb (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .irq_pending_i  (sys_if.irq_pending_i),
        .irq_enable_i   (sys_if.irq_enable_i),
        .pipe_empty_i   (w_pipe_empty),
        .mem_ready_i    (sys_if.mem_ready_i),
        .long_ready_i   (sys_if.long_ready_i),
        .commit_v_i     (sys_if.commit_v_i),
        .ready_o        (sys_if.ready_o),
        .irq_v_o        (sys_if.irq_v_o),
        .irq_id_o       (sys_if.irq_id_o),
        .state_o        (w_irq_state)
    );

`ifdef BP_BE_PIPE_SYS_GEN_STATS_EN
    logic [31:0] stat_irq_cnt_q;
    logic [31:0] stat_drain_cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stat_irq_cnt_q   <= '0;
            stat_drain_cnt_q <= '0;
        end else begin
            if (w_irq_state == e_sys_take)  stat_irq_cnt_q   <= stat_irq_cnt_q + 32'd1;
            if (w_irq_state == e_sys_drain) stat_drain_cnt_q <= stat_drain_cnt_q + 32'd1;
        end
    end

    assign sys_if.stat_irq_cnt_o   = stat_irq_cnt_q;
    assign sys_if.stat_drain_cnt_o = stat_drain_cnt_q;
`else
    logic w_unused_state;
    assign w_unused_state          = ^w_irq_state;
    assign sys_if.stat_irq_cnt_o   = '0;
    assign sys_if.stat_drain_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_be_pipe_sys_gen.sv
// ============================================================================
// Module : tb_bp_be_pipe_sys_gen
// Brief  : Scoreboard bench for the system pipe and interrupt drain/take.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bp_be_pipe_sys_gen;
    import bp_be_pkg::*;

    localparam int VADDR  = 39;
    localparam int INSTR  = 32;
    localparam int DATA   = 64;
    localparam int STAGES = 3;
    localparam int NIRQ   = 3;
`ifdef BP_BE_PIPE_SYS_GEN_STATS_EN
    localparam int STATS_ON = 1;
`else
    localparam int STATS_ON = 0;
`endif

    typedef struct {
        int               due;
        logic             csr_v;
        logic [3:0]       op;
        logic [11:0]      addr;
        logic [DATA-1:0]  data;
        logic [VADDR-1:0] pc;
        logic [INSTR-1:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic exp_ready = 1'b1;
    logic exp_irq   = 1'b0;
    logic [1:0] exp_irq_id = 2'd0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bp_be_pipe_sys_gen_if #(
        .vaddr_width_p(VADDR), .instr_width_p(INSTR),
        .csr_data_width_p(DATA), .num_irq_p(NIRQ)
    ) sif ();

    bp_be_pipe_sys_gen #(
        .vaddr_width_p(VADDR), .instr_width_p(INSTR), .csr_data_width_p(DATA),
        .stages_p(STAGES), .num_irq_p(NIRQ)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .sys_if  (sif.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: compare outputs at negedge, update the scoreboard, advance.
    task automatic tick();
        exp_t e;
        logic exp_cv;
        @(negedge clk);
        exp_cv = (sb.size() > 0) && (sb[0].due == cyc);
        check("commit_v", sif.commit_v_o, exp_cv);
        if (exp_cv) begin
            e = sb.pop_front();
            check("commit_pc",    sif.commit_pc_o,       e.pc);
            check("commit_instr", sif.commit_instr_o,    e.instr);
            check("commit_op",    sif.commit_csr_op_o,   e.op);
            check("commit_addr",  sif.commit_csr_addr_o, e.addr);
            check("commit_data",  sif.commit_csr_data_o, e.data);
            check("csr_fire",     sif.commit_csr_v_o,
                  e.csr_v & sif.commit_v_i & ~sif.exc_v_i);
        end else begin
            check("csr_fire_idle", sif.commit_csr_v_o, 1'b0);
        end
        check("ready", sif.ready_o, exp_ready);
        check("irq_v", sif.irq_v_o, exp_irq);
        if (exp_irq) check("irq_id", sif.irq_id_o, exp_irq_id);
        if (sif.flush_i) sb.delete();
        if (sif.v_i && !sif.poison_i && !sif.flush_i) begin
            e.due   = cyc + STAGES;
            e.csr_v = sif.csr_v_i;
            e.op    = sif.csr_op_i;
            e.addr  = sif.csr_addr_i;
            e.data  = sif.csr_data_i;
            e.pc    = sif.pc_i;
            e.instr = sif.instr_i;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic dispatch(input logic v, input logic poison, input logic flush,
                            input logic csr_v, input logic [VADDR-1:0] pc);
        sif.v_i        = v;
        sif.poison_i   = poison;
        sif.flush_i    = flush;
        sif.csr_v_i    = csr_v;
        sif.pc_i       = pc;
        sif.csr_op_i   = 4'($urandom);
        sif.csr_addr_i = 12'($urandom);
        sif.csr_data_i = {$urandom, $urandom};
        sif.instr_i    = $urandom;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VADDR-1:0] rpc;
        dispatch(1'b0, 1'b0, 1'b0, 1'b0, '0);
        sif.commit_v_i    = 1'b0;
        sif.exc_v_i       = 1'b0;
        sif.mem_ready_i   = 1'b1;
        sif.long_ready_i  = 1'b1;
        sif.irq_pending_i = '0;
        sif.irq_enable_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",    sif.ready_o, 1'b1);
        check("rst_commit_v", sif.commit_v_o, 1'b0);
        check("rst_csr_v",    sif.commit_csr_v_o, 1'b0);
        check("rst_pc",       sif.commit_pc_o, '0);
        check("rst_irq_v",    sif.irq_v_o, 1'b0);
        check("rst_irq_id",   sif.irq_id_o, '0);
        check("rst_stat_irq", sif.stat_irq_cnt_o, '0);
        check("rst_stat_drn", sif.stat_drain_cnt_o, '0);
        rst = 1'b0;

        // CSR dispatch, commit at the last stage only
        for (int c = 0; c < 6; c++) begin
            dispatch(c == 0, 1'b0, 1'b0, 1'b1, 39'h0_8000_0000);
            sif.commit_v_i = (c == STAGES);
            tick();
        end

        // Poisoned and flushed dispatches never commit
        for (int c = 0; c < 6; c++) begin
            dispatch(c < 2, c == 0, c == 2, 1'b1, 39'h100 + 39'(c));
            tick();
        end

        // Exception blocks the CSR side effect
        for (int c = 0; c < 5; c++) begin
            dispatch(c == 0, 1'b0, 1'b0, 1'b1, 39'h200);
            sif.commit_v_i = 1'b1;
            sif.exc_v_i    = 1'b1;
            tick();
        end
        sif.commit_v_i = 1'b0;
        sif.exc_v_i    = 1'b0;

        // Random traffic
        for (int c = 0; c < 40; c++) begin
            rpc = {$urandom, $urandom};
            dispatch(1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                     1'($urandom), rpc);
            sif.commit_v_i = 1'($urandom);
            sif.exc_v_i    = ($urandom_range(0, 3) == 0);
            tick();
        end
        dispatch(1'b0, 1'b0, 1'b0, 1'b0, '0);
        sif.commit_v_i = 1'b0;
        sif.exc_v_i    = 1'b0;
        repeat (4) tick();

        // Priority: line 1 wins over 2; take waits for empty pipe and long pipe
        sif.irq_enable_i = 3'b111;
        exp_irq_id = 2'd1;
        for (int c = 0; c < 9; c++) begin
            dispatch(c == 0, 1'b0, 1'b0, 1'b0, 39'h300);
            sif.irq_pending_i = (c < 6) ? 3'b110 : 3'b000;
            sif.long_ready_i  = (c >= 5);
            exp_ready = (c == 0) || (c >= 7);
            exp_irq   = (c == 6);
            tick();
        end
        check("irq_id_hold", sif.irq_id_o, 2'd1);

        // Withdrawn interrupt returns to idle without a take
        sif.irq_enable_i = 3'b001;
        for (int c = 0; c < 5; c++) begin
            sif.irq_pending_i = (c < 2) ? 3'b001 : 3'b000;
            sif.long_ready_i  = 1'b0;
            exp_ready = !(c == 1 || c == 2);
            exp_irq   = 1'b0;
            tick();
        end
        sif.long_ready_i = 1'b1;

        // One-cycle drain to a take of line 0
        exp_irq_id = 2'd0;
        for (int c = 0; c < 4; c++) begin
            sif.irq_pending_i = (c < 2) ? 3'b001 : 3'b000;
            exp_ready = (c == 0) || (c == 3);
            exp_irq   = (c == 2);
            tick();
        end
        check("stat_irq",   sif.stat_irq_cnt_o,   (STATS_ON != 0) ? 32'd2 : 32'd0);
        check("stat_drain", sif.stat_drain_cnt_o, (STATS_ON != 0) ? 32'd8 : 32'd0);

        // Reset during drain aborts it with no pulse
        sif.irq_pending_i = 3'b001;
        sif.long_ready_i  = 1'b0;
        exp_ready = 1'b1;
        tick();
        exp_ready = 1'b0;
        tick();
        rst = 1'b1;
        sif.irq_pending_i = '0;
        #2;
        check("mid_rst_ready",    sif.ready_o, 1'b1);
        check("mid_rst_irq_v",    sif.irq_v_o, 1'b0);
        check("mid_rst_stat_irq", sif.stat_irq_cnt_o, '0);
        check("mid_rst_stat_drn", sif.stat_drain_cnt_o, '0);
        exp_ready = 1'b1;
        tick();
        rst = 1'b0;
        sif.long_ready_i = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
